instr_decode_queue: RTL and testbench
=====================================

// Module: instr_decode_queue
// PURPOSE
//  Parametrised successor to the single-cycle instruction identifier.
//  - Sits between fetch and ID/EX. Accepts {pc, instr} beats on a valid/ready handshake.
//  - Decodes each beat to an instruction ID plus an illegal flag at enqueue time.
//  - Buffers up to DEPTH decoded entries in FIFO order and presents the head to the
//    execute side on a second valid/ready handshake.
//  - Adds over the identifier: BRANCH decode, optional M-extension decode, illegal
//    detection, buffering, backpressure, flush.
// PARAMETERS
//  XLEN    32  PC/instruction width (instruction field fixed at 32 bits)
//  DEPTH   4   queue entries; power of two, >=2
//  EN_M    0   1: decode MUL..REMU under opcode OP; 0: those encodings are illegal
// PORTS
//  clk         in   1             clock, all state on rising edge
//  rst_n       in   1             asynchronous, active-low reset
//  flush_i     in   1             discard all entries (branch mispredict / trap)
//  in_valid_i  in   1             fetch beat valid
//  in_ready_o  out  1             queue can accept a beat
//  in_pc_i     in   XLEN          PC of beat
//  in_instr_i  in   32            raw instruction
//  out_valid_o out  1             head entry valid
//  out_ready_i in   1             consumer takes head
//  out_pc_o    out  XLEN          head PC
//  out_instr_o out  32            head raw instruction
//  out_id_o    out  `INST_ID_LEN  head instruction ID
//  out_ill_o   out  1             head is an illegal instruction
//  count_o     out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset (async assert, sync release)
//  - wr_ptr = rd_ptr = count = 0; out_valid_o = 0; in_ready_o = 1.
//  - out_* data = 0, out_id_o = `NONE_ID.
//  Handshakes
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - in_ready_o = (count != DEPTH); no pass-through while full.
//  - out_valid_o = (count != 0). Head data is driven straight from storage (no extra register).
//  - Latency: beat pushed in cycle N is visible at the head in cycle N+1 when the queue was empty.
//  - Once out_valid_o is high, head data stays stable until pop or flush.
//  Pointers and occupancy
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - count update: +1 on push only, -1 on pop only, unchanged on push & pop in the same
//    cycle. Same-cycle push & pop is legal at any non-full, non-empty occupancy.
//  - Full: push cannot occur. Empty: pop cannot occur.
//  Flush
//  - Highest priority. Next cycle count = 0 and pointers = 0.
//  - Any same-cycle push or pop is discarded; the beat is not stored.
//  - in_ready_o stays combinational and is unaffected by flush in the flush cycle.
//  Decode (combinational on in_instr_i, stored with the entry)
//  - Fields: opcode [6:0], funct3 [14:12], funct7 [31:25].
//  - Classes: OP_IMM, OP, LUI, AUIPC, LOAD, STORE, JAL, JALR, BRANCH.
//  - Illegal, giving id = `NONE_ID and ill = 1:
//    - unknown opcode;
//    - JALR with funct3 != 0;
//    - LOAD with funct3 in {3,6,7};
//    - STORE with funct3 >= 3;
//    - BRANCH with funct3 in {2,3};
//    - SLLI with funct7 != 0;
//    - SRLI/SRAI with funct7 not in {0x00, 0x20};
//    - OP with funct7 = 0x20 except ADD->SUB and SRL->SRA;
//    - OP with funct7 = 0x01 while EN_M = 0;
//    - OP with any other funct7.
//  - Legal instructions get ill = 0 and their `*_ID value.
// STRUCTURE
//  - Shared package/defines: opcode constants, `INST_ID_LEN, all `*_ID values (new BRANCH
//    and M IDs included), funct7 constants 0x00/0x20/0x01.
//  - One sub-module: instr_id_decoder. Purely combinational; maps
//    (opcode, funct3, funct7, EN_M) to {id, ill}; reusable by other stages.
//  - Storage: flop array DEPTH x (XLEN+32+`INST_ID_LEN+1). No RAM macro.
// TESTING
//  1 Reset: hold rst_n=0 mid-traffic -> out_valid_o=0, count_o=0 and in_ready_o=1
//    immediately, no clock edge needed.
//  2 Push pc=0x100, instr=0x00500093 (addi x1,x0,5) -> next cycle out_valid_o=1,
//    out_id_o=ADDI_ID, out_ill_o=0, out_pc_o=0x100.
//  3 Push 4 beats with out_ready_i=0 (DEPTH=4) -> count_o=4, in_ready_o=0, 5th beat held.
//    Then pop every cycle -> FIFO order preserved across pointer wrap.
//  4 At count=2, push and pop in the same cycle -> count_o stays 2. Popped entry is the
//    oldest; new entry lands at the tail.
//  5 instr=0x02208033 (mul) with EN_M=0 -> out_ill_o=1, out_id_o=`NONE_ID.
//    With EN_M=1 -> MUL_ID, ill=0. Also instr=0x0000006B -> ill=1.
//  6 count=3 with flush_i=1 and in_valid_i=1 in the same cycle -> next cycle count_o=0,
//    out_valid_o=0, and the beat is not stored.

Source files
------------

// File: rtl/instr_decode_queue_pkg.sv
// Shared decode constants for the fetch-side instruction queue: opcodes, funct7
// values and the instruction ID encoding used by every stage that consumes it.
package instr_decode_queue_pkg;

    localparam int INST_ID_LEN = 6;

    typedef enum logic [INST_ID_LEN-1:0] {
        NONE_ID = '0,
        LUI_ID, AUIPC_ID, JAL_ID, JALR_ID,
        BEQ_ID, BNE_ID, BLT_ID, BGE_ID, BLTU_ID, BGEU_ID,
        LB_ID, LH_ID, LW_ID, LBU_ID, LHU_ID,
        SB_ID, SH_ID, SW_ID,
        ADDI_ID, SLTI_ID, SLTIU_ID, XORI_ID, ORI_ID, ANDI_ID,
        SLLI_ID, SRLI_ID, SRAI_ID,
        ADD_ID, SUB_ID, SLL_ID, SLT_ID, SLTU_ID, XOR_ID, SRL_ID, SRA_ID, OR_ID, AND_ID,
        MUL_ID, MULH_ID, MULHSU_ID, MULHU_ID, DIV_ID, DIVU_ID, REM_ID, REMU_ID
    } inst_id_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

endpackage

// File: rtl/instr_decode_queue_decoder.sv
// Purely combinational instruction identifier: (opcode, funct3, funct7) -> {id, ill}.
// Any encoding not recognised maps to NONE_ID and raises ill.
module instr_id_decoder
    import instr_decode_queue_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output inst_id_e   id,
    output logic       ill
);

    // NOTE: id gets its default before the case so every path assigns it; no latch.
    always_comb begin
        id = NONE_ID;
        case (opcode)
            OPC_LUI:   id = LUI_ID;
            OPC_AUIPC: id = AUIPC_ID;
            OPC_JAL:   id = JAL_ID;
            OPC_JALR:  if (funct3 == 3'd0) id = JALR_ID;
            OPC_BRANCH: begin
                case (funct3)
                    3'd0:    id = BEQ_ID;
                    3'd1:    id = BNE_ID;
                    3'd4:    id = BLT_ID;
                    3'd5:    id = BGE_ID;
                    3'd6:    id = BLTU_ID;
                    3'd7:    id = BGEU_ID;
                    default: id = NONE_ID;
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'd0:    id = LB_ID;
                    3'd1:    id = LH_ID;
                    3'd2:    id = LW_ID;
                    3'd4:    id = LBU_ID;
                    3'd5:    id = LHU_ID;
                    default: id = NONE_ID;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'd0:    id = SB_ID;
                    3'd1:    id = SH_ID;
                    3'd2:    id = SW_ID;
                    default: id = NONE_ID;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'd0: id = ADDI_ID;
                    3'd1: if (funct7 == F7_BASE) id = SLLI_ID;
                    3'd2: id = SLTI_ID;
                    3'd3: id = SLTIU_ID;
                    3'd4: id = XORI_ID;
                    3'd5: begin
                        if (funct7 == F7_BASE)     id = SRLI_ID;
                        else if (funct7 == F7_ALT) id = SRAI_ID;
                    end
                    3'd6: id = ORI_ID;
                    3'd7: id = ANDI_ID;
                endcase
            end
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'd0: id = ADD_ID;
                            3'd1: id = SLL_ID;
                            3'd2: id = SLT_ID;
                            3'd3: id = SLTU_ID;
                            3'd4: id = XOR_ID;
                            3'd5: id = SRL_ID;
                            3'd6: id = OR_ID;
                            3'd7: id = AND_ID;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'd0)      id = SUB_ID;
                        else if (funct3 == 3'd5) id = SRA_ID;
                    end
                    F7_MULDIV: begin
                        // Without the M extension the whole funct7=0x01 space stays illegal.
                        if (EN_M) begin
                            case (funct3)
                                3'd0: id = MUL_ID;
                                3'd1: id = MULH_ID;
                                3'd2: id = MULHSU_ID;
                                3'd3: id = MULHU_ID;
                                3'd4: id = DIV_ID;
                                3'd5: id = DIVU_ID;
                                3'd6: id = REM_ID;
                                3'd7: id = REMU_ID;
                            endcase
                        end
                    end
                    default: id = NONE_ID;
                endcase
            end
            default: id = NONE_ID;
        endcase
    end

    assign ill = (id == NONE_ID);

endmodule

// File: rtl/instr_decode_queue.sv
// Decoding instruction queue between fetch and ID/EX: decodes each beat on entry,
// buffers DEPTH entries in FIFO order and presents the head straight from storage.
module instr_decode_queue
    import instr_decode_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter bit EN_M  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic [31:0]                in_instr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [31:0]                out_instr_o,
    output logic [INST_ID_LEN-1:0]     out_id_o,
    output logic                       out_ill_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        inst_id_e        id;
        logic            ill;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    inst_id_e dec_id;
    logic     dec_ill;
    logic     push, pop;

    instr_id_decoder #(.EN_M(EN_M)) u_decoder (
        .opcode (in_instr_i[6:0]),
        .funct3 (in_instr_i[14:12]),
        .funct7 (in_instr_i[31:25]),
        .id     (dec_id),
        .ill    (dec_ill)
    );

    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage is reset because the head is driven directly from it and must read
    // as zero data with NONE_ID out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: '0, id: NONE_ID, ill: 1'b0};
            end
        end else if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc_i, instr: in_instr_i, id: dec_id, ill: dec_ill};
        end
    end

    assign out_pc_o    = mem_q[rd_ptr_q].pc;
    assign out_instr_o = mem_q[rd_ptr_q].instr;
    assign out_id_o    = mem_q[rd_ptr_q].id;
    assign out_ill_o   = mem_q[rd_ptr_q].ill;
    assign count_o     = count_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: a decode vector table run through two instances
// (EN_M=0 and EN_M=1) plus hand-written reset, full, wrap, push&pop and flush sequences.
module tb_instr_decode_queue;
    import instr_decode_queue_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i, in_valid_i, out_ready_i;
    logic [XLEN-1:0]  in_pc_i;
    logic [31:0]      in_instr_i;

    logic             in_ready, out_valid, out_ill;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [INST_ID_LEN-1:0] out_id;
    logic [2:0]       count;

    logic             in_ready_m, out_valid_m, out_ill_m;
    logic [XLEN-1:0]  out_pc_m;
    logic [31:0]      out_instr_m;
    logic [INST_ID_LEN-1:0] out_id_m;
    logic [2:0]       count_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready), .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
        .out_valid_o(out_valid), .out_ready_i(out_ready_i), .out_pc_o(out_pc),
        .out_instr_o(out_instr), .out_id_o(out_id), .out_ill_o(out_ill), .count_o(count)
    );

    instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1'b1)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_m), .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
        .out_valid_o(out_valid_m), .out_ready_i(out_ready_i), .out_pc_o(out_pc_m),
        .out_instr_o(out_instr_m), .out_id_o(out_id_m), .out_ill_o(out_ill_m), .count_o(count_m)
    );

    typedef struct {
        logic [31:0] instr;
        inst_id_e    id0;
        logic        ill0;
        inst_id_e    id1;
        logic        ill1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] instr, input inst_id_e id0, input inst_id_e id1);
        vec_t v;
        v.instr = instr;
        v.id0   = id0;
        v.ill0  = (id0 == NONE_ID);
        v.id1   = id1;
        v.ill1  = (id1 == NONE_ID);
        vecs.push_back(v);
    endtask

    task automatic push_beat(input logic [31:0] pc, input logic [31:0] instr);
        in_valid_i = 1'b1;
        in_pc_i    = pc;
        in_instr_i = instr;
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_pc_i = '0; in_instr_i = '0;

        add(32'h00500093, ADDI_ID, ADDI_ID);
        add(32'h02208033, NONE_ID, MUL_ID);
        add(32'h0000006B, NONE_ID, NONE_ID);
        add(32'h403100B3, SUB_ID,  SUB_ID);
        add(32'h40001033, NONE_ID, NONE_ID);
        add(32'h40005033, SRA_ID,  SRA_ID);
        add(32'h40005013, SRAI_ID, SRAI_ID);
        add(32'h40001013, NONE_ID, NONE_ID);
        add(32'h00005013, SRLI_ID, SRLI_ID);
        add(32'h000010B7, LUI_ID,  LUI_ID);
        add(32'h00000017, AUIPC_ID, AUIPC_ID);
        add(32'h0000006F, JAL_ID,  JAL_ID);
        add(32'h00000067, JALR_ID, JALR_ID);
        add(32'h00001067, NONE_ID, NONE_ID);
        add(32'h00002003, LW_ID,   LW_ID);
        add(32'h00003003, NONE_ID, NONE_ID);
        add(32'h00005003, LHU_ID,  LHU_ID);
        add(32'h00002023, SW_ID,   SW_ID);
        add(32'h00003023, NONE_ID, NONE_ID);
        add(32'h00000063, BEQ_ID,  BEQ_ID);
        add(32'h00002063, NONE_ID, NONE_ID);
        add(32'h00007063, BGEU_ID, BGEU_ID);
        add(32'h04000033, NONE_ID, NONE_ID);
        add(32'h02007033, NONE_ID, REMU_ID);
        add(32'h00007033, AND_ID,  AND_ID);
        add(32'h02005013, NONE_ID, NONE_ID);

        // Reset state, sampled while rst_n is still low.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_count",     count,     0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_id",    out_id,    NONE_ID);
        check("rst_out_pc",    out_pc,    0);
        check("rst_out_instr", out_instr, 0);
        rst_n = 1'b1;
        tick();

        // Decode table: one beat into an empty queue, visible next cycle, then popped.
        for (int i = 0; i < vecs.size(); i++) begin
            push_beat(32'h100 + 32'(4 * i), vecs[i].instr);
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_count", i), count, 1);
            check($sformatf("v%0d_pc", i),    out_pc, 32'h100 + 32'(4 * i));
            check($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
            check($sformatf("v%0d_id", i),    out_id, vecs[i].id0);
            check($sformatf("v%0d_ill", i),   out_ill, vecs[i].ill0);
            check($sformatf("v%0d_id_m", i),  out_id_m, vecs[i].id1);
            check($sformatf("v%0d_ill_m", i), out_ill_m, vecs[i].ill1);
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
        end
        check("table_empty", count, 0);

        // Same-cycle push and pop at count 2.
        push_beat(32'h300, 32'h00100093);
        push_beat(32'h304, 32'h00200093);
        check("pp_count_before", count, 2);
        in_valid_i = 1'b1; in_pc_i = 32'h308; in_instr_i = 32'h00300093;
        out_ready_i = 1'b1;
        check("pp_head_oldest", out_pc, 32'h300);
        tick();
        in_valid_i = 1'b0;
        check("pp_count_after", count, 2);
        check("pp_head_next", out_pc, 32'h304);
        tick();
        check("pp_tail_pc", out_pc, 32'h308);
        check("pp_tail_instr", out_instr, 32'h00300093);
        tick();
        out_ready_i = 1'b0;
        check("pp_empty", count, 0);

        // Fill to DEPTH across the pointer wrap, hold a 5th beat, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            push_beat(32'h400 + 32'(4 * i), 32'h00000093 | (32'(i) << 20));
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        in_valid_i = 1'b1; in_pc_i = 32'h410; in_instr_i = 32'h00500093;
        tick();
        in_valid_i = 1'b0;
        check("full_held_count", count, 4);
        check("full_held_head", out_pc, 32'h400);
        out_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d_pc", i), out_pc, 32'h400 + 32'(4 * i));
            check($sformatf("drain%0d_instr", i), out_instr, 32'h00000093 | (32'(i) << 20));
            tick();
        end
        out_ready_i = 1'b0;
        check("drain_count", count, 0);
        check("drain_valid", out_valid, 0);

        // Flush at count 3 with a beat offered in the same cycle.
        for (int i = 0; i < 3; i++) push_beat(32'h500 + 32'(4 * i), 32'h00000013);
        check("fl_count_before", count, 3);
        flush_i = 1'b1;
        in_valid_i = 1'b1; in_pc_i = 32'h5FC; in_instr_i = 32'h00700093;
        check("fl_in_ready", in_ready, 1);
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("fl_count_after", count, 0);
        check("fl_valid_after", out_valid, 0);
        push_beat(32'h600, 32'h00800093);
        check("fl_new_count", count, 1);
        check("fl_new_head", out_pc, 32'h600);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Asynchronous reset in the middle of traffic, checked before any clock edge.
        push_beat(32'h700, 32'h00900093);
        in_valid_i = 1'b1; in_pc_i = 32'h704; in_instr_i = 32'h00A00093;
        tick();
        in_valid_i = 1'b0;
        check("mid_count_before", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_pc", out_pc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_release", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
